input_conditioner: RTL

Conditions the raw board inputs (BTN_LEFT, BTN_RIGHT, BTN_A, BTN_B, SW_PAUSE) before they reach the game logic. The block synchronises every input and debounces it. It resolves left/right conflicts and latches a ball-release request until the game logic consumes it. It also generates the pause-gated per-frame update strobe from the renderer's FRAME_DONE. It sits directly upstream of the game-logic stage in the top level.

---
 rtl/input_conditioner_if.sv | 25 ++
 rtl/input_conditioner.sv | 103 ++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw board inputs and conditioned game-logic controls
interface input_conditioner_if;
    logic BTN_LEFT_RAW;
    logic BTN_RIGHT_RAW;
    logic BTN_A_RAW;
    logic BTN_B_RAW;
    logic SW_PAUSE_RAW;
    logic FRAME_DONE;
    logic LEFT_HELD;
    logic RIGHT_HELD;
    logic RELEASE_REQ;
    logic PAUSED;
    logic START_UPDATE;

    // master: board/renderer side that drives the raw inputs
    modport master (
        output BTN_LEFT_RAW, BTN_RIGHT_RAW, BTN_A_RAW, BTN_B_RAW, SW_PAUSE_RAW, FRAME_DONE,
        input  LEFT_HELD, RIGHT_HELD, RELEASE_REQ, PAUSED, START_UPDATE
    );

    modport slave (
        input  BTN_LEFT_RAW, BTN_RIGHT_RAW, BTN_A_RAW, BTN_B_RAW, SW_PAUSE_RAW, FRAME_DONE,
        output LEFT_HELD, RIGHT_HELD, RELEASE_REQ, PAUSED, START_UPDATE
    );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and condition board inputs for game logic
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input_conditioner_if.slave   io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int N  = 5;
    localparam int IDX_LEFT  = 0;
    localparam int IDX_RIGHT = 1;
    localparam int IDX_A     = 2;
    localparam int IDX_B     = 3;
    localparam int IDX_PAUSE = 4;

    logic [N-1:0] raw;
    logic [N-1:0] deb;

    assign raw = {io.SW_PAUSE_RAW, io.BTN_B_RAW, io.BTN_A_RAW, io.BTN_RIGHT_RAW, io.BTN_LEFT_RAW};

    for (genvar g = 0; g < N; g++) begin : g_in
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_q;
        logic [CW-1:0]          cnt_q;
        logic                   synced;

        assign synced = sync_q[SYNC_STAGES-1];

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
            end
        end

        // Counter only runs while the synchronised level disagrees with the
        // debounced state; any agreement (a glitch ending) restarts it.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                s_q   <= 1'b0;
                cnt_q <= '0;
            end else if (synced == s_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                s_q   <= synced;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign deb[g] = s_q;
    end

    logic left_q;
    logic right_q;
    logic paused_q;
    logic start_q;
    logic req_q;
    logic any_q;
    logic release_any;
    logic release_rise;

    assign release_any  = deb[IDX_A] | deb[IDX_B];
    assign release_rise = release_any & ~any_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            paused_q <= 1'b0;
            start_q  <= 1'b0;
            any_q    <= 1'b0;
        end else begin
            left_q   <= deb[IDX_LEFT] & ~deb[IDX_RIGHT];
            right_q  <= deb[IDX_RIGHT] & ~deb[IDX_LEFT];
            paused_q <= deb[IDX_PAUSE];
            start_q  <= io.FRAME_DONE & ~paused_q;
            any_q    <= release_any;
        end
    end

    // A new press landing on the consuming frame must survive to the next frame,
    // so set takes priority over the START_UPDATE clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_q <= 1'b0;
        end else if (release_rise) begin
            req_q <= 1'b1;
        end else if (start_q) begin
            req_q <= 1'b0;
        end
    end

    assign io.LEFT_HELD    = left_q;
    assign io.RIGHT_HELD   = right_q;
    assign io.PAUSED       = paused_q;
    assign io.START_UPDATE = start_q;
    assign io.RELEASE_REQ  = req_q;
endmodule
